// File: rtl/mii_relay_pkg.sv
// Shared types and constants for the MII store-and-forward relay.
package mii_relay_pkg;

  localparam int unsigned STAT_W     = 16;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_e;

  // Buffer entry layout at the default beat width: {last, data}
  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } relay_entry_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mii_relay_ram.sv
// Simple dual-port buffer: one write port, one read port with a registered output
// that returns zero whenever no read was issued in the previous cycle.
module mii_relay_ram
  import mii_relay_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = '0;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mii_store_fwd_relay.sv
// Store-and-forward MII byte relay with overflow drop and programmable inter-frame gap.
// Optional FRAME_STATS_EN adds saturating accepted/dropped frame counters.
module mii_store_fwd_relay
  import mii_relay_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rxd,
  input  logic              rx_dv,
  output logic [DATA_W-1:0] txd,
  output logic              tx_en,
  output logic              frame_drop,
  output logic              buf_empty
`ifdef FRAME_STATS_EN
  ,
  output logic [STAT_W-1:0] rx_frame_cnt,
  output logic [STAT_W-1:0] drop_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_W + 1;
  localparam int unsigned GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              bad_q, bad_d;
  logic              rx_sync_q, rx_sync_d;
  logic              frame_drop_q, frame_drop_d;
  logic              buf_empty_q, buf_empty_d;
  logic              tx_en_q, tx_en_d;
  tx_state_e         state_q, state_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

  logic              ram_we, ram_re;
  entry_t            ram_wentry, rd_entry;
  logic [EW-1:0]     ram_rdata;
  logic [PW-1:0]     frame_len_c;
  logic              full_c, avail_c, last_wr_c, bad_now_c;

  mii_relay_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (ram_wentry),
    .re    (ram_re),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign rd_entry    = entry_t'(ram_rdata);
  assign full_c      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign avail_c     = (rd_ptr_q != wr_cmt_q);
  assign frame_len_c = wr_ptr_q - wr_cmt_q;
  assign last_wr_c   = hold_vld_q & ~rx_dv;
  // A frame that would reach DEPTH entries can never commit, so it is marked bad early
  assign bad_now_c   = bad_q | (hold_vld_q & (full_c | (frame_len_c == PW'(DEPTH - 1))));

  // Receive side: one-byte hold, write, commit or rewind at frame end
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_cmt_d     = wr_cmt_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    bad_d        = bad_q;
    rx_sync_d    = rx_sync_q | ~rx_dv;
    frame_drop_d = 1'b0;
    ram_we       = 1'b0;
    ram_wentry   = '0;

    if (rx_sync_q) begin
      hold_vld_d = rx_dv;
      if (rx_dv) hold_d = rxd;
    end

    if (hold_vld_q && !bad_now_c) begin
      ram_we          = 1'b1;
      ram_wentry.last = last_wr_c;
      ram_wentry.data = hold_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      if (last_wr_c) wr_cmt_d = wr_ptr_q + PW'(1);
    end

    if (last_wr_c) begin
      bad_d = 1'b0;
      if (bad_now_c) begin
        wr_ptr_d     = wr_cmt_q;
        frame_drop_d = 1'b1;
      end
    end else begin
      bad_d = bad_now_c;
    end
  end

  // Transmit side: the final gap cycle may launch the next frame so the gap is exact
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    tx_en_d   = 1'b0;
    ram_re    = 1'b0;

    case (state_q)
      IDLE: begin
        if (avail_c) begin
          ram_re  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rd_entry.last) begin
          state_d   = GAP;
          gap_cnt_d = '0;
        end else begin
          ram_re = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(IFG_CYCLES - 1)) begin
          if (avail_c) begin
            ram_re  = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (ram_re) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      tx_en_d  = 1'b1;
    end
  end

  assign buf_empty_d = (rd_ptr_d == wr_cmt_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      wr_cmt_q     <= '0;
      rd_ptr_q     <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      bad_q        <= 1'b0;
      rx_sync_q    <= ~rx_dv;
      frame_drop_q <= 1'b0;
      buf_empty_q  <= 1'b1;
      tx_en_q      <= 1'b0;
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wr_cmt_q     <= wr_cmt_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      bad_q        <= bad_d;
      rx_sync_q    <= rx_sync_d;
      frame_drop_q <= frame_drop_d;
      buf_empty_q  <= buf_empty_d;
      tx_en_q      <= tx_en_d;
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign txd        = rd_entry.data;
  assign tx_en      = tx_en_q;
  assign frame_drop = frame_drop_q;
  assign buf_empty  = buf_empty_q;

`ifdef FRAME_STATS_EN
  logic [STAT_W-1:0] rx_frame_cnt_q, rx_frame_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    rx_frame_cnt_d = rx_frame_cnt_q;
    drop_cnt_d     = drop_cnt_q;
    if (ram_we && ram_wentry.last) rx_frame_cnt_d = sat_inc(rx_frame_cnt_q);
    if (frame_drop_d)              drop_cnt_d     = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_frame_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      rx_frame_cnt_q <= rx_frame_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign rx_frame_cnt = rx_frame_cnt_q;
  assign drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mii_store_fwd_relay.sv
// Scoreboard bench for mii_store_fwd_relay (DEPTH=8, IFG_CYCLES=12).
module tb_mii_store_fwd_relay;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 8;
  localparam int unsigned IFG = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rxd;
  logic          rx_dv;
  logic [DW-1:0] txd;
  logic          tx_en;
  logic          frame_drop;
  logic          buf_empty;
`ifdef FRAME_STATS_EN
  logic [15:0]   rx_frame_cnt;
  logic [15:0]   drop_cnt;
`endif

  mii_store_fwd_relay #(.DATA_W(DW), .DEPTH(DEP), .IFG_CYCLES(IFG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_dv      (rx_dv),
    .txd        (txd),
    .tx_en      (tx_en),
    .frame_drop (frame_drop),
    .buf_empty  (buf_empty)
`ifdef FRAME_STATS_EN
    ,
    .rx_frame_cnt (rx_frame_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] frm[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            drop_pulses = 0;
  int            rise_cyc = 0;
  int            last_gap = 0;
  int            idle_run = 0;
  int            mon_st   = 0;
  logic          prev_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every tx_en beat and checks framing
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      mon_st   = 0;
      prev_en  = 1'b0;
      idle_run = 0;
    end else begin
      if (frame_drop) drop_pulses++;
      if (mon_st == 1) chk("tx_cont", tx_en, 1);
      if (mon_st == 2) chk("tx_end", tx_en, 0);
      mon_st = 0;
      if (tx_en) begin
        if (!prev_en) begin
          rise_cyc = cyc;
          last_gap = idle_run;
        end
        idle_run = 0;
        chk("tx_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("txd", txd, e.d);
          mon_st = e.last ? 2 : 1;
        end
      end else begin
        idle_run++;
        chk("txd_idle", txd, 0);
      end
      prev_en = tx_en;
    end
  end

  task automatic make_frame(input int n, input logic [DW-1:0] base);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(DW'(base + i));
  endtask

  // Drives frm; returns in cycle T+1 where T is the first rx_dv=0 cycle
  task automatic send_frame(input bit push, output int t_end);
    for (int i = 0; i < frm.size(); i++) begin
      rxd   = frm[i];
      rx_dv = 1'b1;
      if (push) exp_q.push_back('{d: frm[i], last: (i == frm.size() - 1)});
      @(posedge clk); #1;
    end
    rx_dv = 1'b0;
    rxd   = '0;
    t_end = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_en) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, exp_q.size(), 0);
    repeat (IFG + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int tx_cnt;
    rst_n = 1'b0;
    rxd   = '0;
    rx_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", tx_en, 0);
    chk("rst_txd", txd, 0);
    chk("rst_drop", frame_drop, 0);
    chk("rst_empty", buf_empty, 1);
`ifdef FRAME_STATS_EN
    chk("rst_rx_cnt", rx_frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tx_en", tx_en, 0);

    // 1) single 4-byte frame, latency and empty flag
    frm = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1'b1, t);
    chk("t1_not_empty", buf_empty, 0);
    wait_drain("t1_drain");
    chk("t1_latency", rise_cyc, t + 2);
    chk("t1_empty", buf_empty, 1);

    // 2) two 3-byte frames, 1-cycle rx gap, exact IFG
    frm = '{8'h01, 8'h02, 8'h03};
    send_frame(1'b1, t);
    frm = '{8'h04, 8'h05, 8'h06};
    send_frame(1'b1, t);
    wait_drain("t2_drain");
    chk("t2_ifg", last_gap, IFG);

    // 3) overflow frame dropped, following frame passes
    drop_pulses = 0;
    make_frame(10, 8'h30);
    send_frame(1'b0, t);
    chk("t3_drop_pulse", frame_drop, 1);
    frm = '{8'hAA, 8'hBB};
    send_frame(1'b1, t);
    wait_drain("t3_drain");
    chk("t3_drop_count", drop_pulses, 1);

    // 3b) DEPTH-1 entries accepted, DEPTH entries dropped
    drop_pulses = 0;
    make_frame(DEP - 1, 8'h50);
    send_frame(1'b1, t);
    make_frame(DEP, 8'h60);
    send_frame(1'b0, t);
    wait_drain("t3b_drain");
    chk("t3b_drop_count", drop_pulses, 1);

    // 4) second frame written while the first drains
    drop_pulses = 0;
    make_frame(5, 8'hC0);
    send_frame(1'b1, t);
    make_frame(4, 8'hD0);
    send_frame(1'b1, t);
    wait_drain("t4_drain");
    chk("t4_no_drop", drop_pulses, 0);
    chk("t4_ifg", last_gap, IFG);

    // 5) reset while byte 2 of 6 is on the wire
    make_frame(6, 8'h61);
    send_frame(1'b1, t);
    @(posedge clk); #1;
    chk("t5_b1_en", tx_en, 1);
    @(posedge clk); #1;
    chk("t5_b2", txd, 8'h62);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_tx_en", tx_en, 0);
    chk("t5_txd", txd, 0);
    chk("t5_empty", buf_empty, 1);
    exp_q.delete();
    rst_n  = 1'b1;
    tx_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (tx_en) tx_cnt++;
    end
    chk("t5_no_resend", tx_cnt, 0);

    // 6) three good frames and one overflow frame
    drop_pulses = 0;
    make_frame(2, 8'h70);
    send_frame(1'b1, t);
    make_frame(DEP + 1, 8'h80);
    send_frame(1'b0, t);
    make_frame(3, 8'h90);
    send_frame(1'b1, t);
    make_frame(4, 8'hA0);
    send_frame(1'b1, t);
    wait_drain("t6_drain");
    chk("t6_drop_count", drop_pulses, 1);
    chk("t6_empty", buf_empty, 1);
`ifdef FRAME_STATS_EN
    chk("t6_rx_frame_cnt", rx_frame_cnt, 3);
    chk("t6_drop_cnt", drop_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
